// File: rtl/pipe_bus_bram_prog_pkg.sv
// Shared types and width/delay helpers for the programmable BRAM delay line.
package pipe_bus_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Pointer / counter width for a buffer of d_max entries.
   function automatic int unsigned ptr_w(input int unsigned d_max);
      return (d_max < 2) ? 1 : $clog2(d_max);
   endfunction

   // Width that can hold a delay value 0..d_max without overflow.
   function automatic int unsigned dly_w(input int unsigned d_max);
      return $clog2(d_max + 1);
   endfunction

   // Clamp a requested delay into 1..d_max.
   function automatic int unsigned sat_delay(input int unsigned req, input int unsigned d_max);
      if (req == 0) return 1;
      if (req > d_max) return d_max;
      return req;
   endfunction

   // A requested delay that had to be clamped.
   function automatic logic delay_oob(input int unsigned req, input int unsigned d_max);
      return (req == 0) || (req > d_max);
   endfunction

endpackage

// File: rtl/pipe_bus_bram_prog_if.sv
// Lane data/valid bus between the upstream stage, the delay line and the consumer.
interface pipe_bus_bram_prog_if #(
   parameter int unsigned W     = 256,
   parameter int unsigned LANES = 4
);
   logic [LANES*W-1:0] din;
   logic [LANES-1:0]   vin;
   logic [LANES*W-1:0] dout;
   logic [LANES-1:0]   vout;

   modport master (output din, output vin, input dout, input vout);
   modport slave  (input din, input vin, output dout, output vout);
endinterface

// File: rtl/pipe_bus_bram_prog_sdp_bram.sv
// Simple dual-port block RAM: per-lane write enables, registered read port.
module sdp_bram #(
   parameter int unsigned W     = 256,
   parameter int unsigned LANES = 4,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_ce,
   input  logic [LANES-1:0]   i_we,
   input  logic [AW-1:0]      i_waddr,
   input  logic [LANES*W-1:0] i_wdata,
   input  logic [AW-1:0]      i_raddr,
   output logic [LANES*W-1:0] o_rdata
);
   (* ram_style = "block" *) logic [LANES*W-1:0] r_mem [DEPTH];
   logic [LANES*W-1:0] r_rdata;

   // Write port: each lane lands only when its enable is set
   always_ff @(posedge clk) begin
      for (int l = 0; l < int'(LANES); l++) begin
         if (i_we[l]) r_mem[i_waddr][l*W +: W] <= i_wdata[l*W +: W];
      end
   end

   // Read port: output register, cleared by reset, frozen by ce
   always_ff @(posedge clk) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_ce) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/pipe_bus_bram_prog.sv
// Multi-lane data+valid delay line with runtime-programmable depth, reload flush and fill tracking.
module pipe_bus_bram_prog
   import pipe_bus_pkg::*;
#(
   parameter int unsigned W         = 256,
   parameter int unsigned LANES     = 4,
   parameter int unsigned D_MAX     = 64,
   parameter int unsigned D_DEFAULT = 6,
   parameter int unsigned USE_V     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_ce,
   input  logic                      i_cfg_load,
   input  logic [dly_w(D_MAX)-1:0]   i_cfg_delay,
   pipe_bus_bram_prog_if.slave       bus,
   output logic                      o_busy,
   output logic [dly_w(D_MAX)-1:0]   o_delay_q,
   output logic                      o_cfg_err
);
   localparam int unsigned PW = ptr_w(D_MAX);
   localparam int unsigned DW = dly_w(D_MAX);

   state_t                      r_state, w_state_nxt;
   logic [PW-1:0]               r_fill_cnt, w_fill_cnt_nxt;
   logic [PW-1:0]               r_wr_ptr, w_rd_ptr, w_last;
   logic [DW-1:0]               r_delay_q, w_delay_sat;
   logic                        r_cfg_err, w_oob, w_bypass;
   logic [LANES-1:0]            w_vin, w_we, r_vout;
   logic [D_MAX-1:0][LANES-1:0] r_valid;
   logic [LANES*W-1:0]          r_byp_data, w_rd_data;

   assign w_bypass    = (r_delay_q == DW'(1));
   assign w_last      = PW'(r_delay_q - DW'(1));
   assign w_rd_ptr    = (r_wr_ptr == w_last) ? '0 : r_wr_ptr + PW'(1);
   assign w_vin       = (USE_V != 0) ? bus.vin : '1;
   assign w_delay_sat = DW'(sat_delay(32'(i_cfg_delay), D_MAX));
   assign w_oob       = delay_oob(32'(i_cfg_delay), D_MAX);
   assign w_we        = (i_ce && !rst && !i_cfg_load) ? w_vin : '0;

   sdp_bram #(.W(W), .LANES(LANES), .DEPTH(D_MAX), .AW(PW)) u_mem (
      .clk     (clk),
      .i_rst   (rst),
      .i_ce    (i_ce),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.din),
      .i_raddr (w_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_FILL;
         r_fill_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
      end
   end

   // FSM next state: count ce-cycles while filling, restart on every reload
   always_comb begin
      w_state_nxt    = r_state;
      w_fill_cnt_nxt = r_fill_cnt;
      if (i_ce) begin
         if (i_cfg_load) begin
            w_state_nxt    = ST_FILL;
            w_fill_cnt_nxt = '0;
         end else begin
            case (r_state)
               ST_FILL: begin
                  if (DW'(r_fill_cnt) == r_delay_q - DW'(1)) w_state_nxt = ST_RUN;
                  else                                      w_fill_cnt_nxt = r_fill_cnt + PW'(1);
               end
               ST_RUN:  w_state_nxt = ST_RUN;
               default: w_state_nxt = ST_FILL;
            endcase
         end
      end
   end

   // Pointers, valid array, bypass path and config; a reload flushes everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_delay_q  <= DW'(D_DEFAULT);
         r_valid    <= '0;
         r_vout     <= '0;
         r_cfg_err  <= 1'b0;
         r_byp_data <= '0;
      end else if (i_ce) begin
         if (i_cfg_load) begin
            r_delay_q <= w_delay_sat;
            r_wr_ptr  <= '0;
            r_valid   <= '0;
            r_vout    <= '0;
            if (w_oob) r_cfg_err <= 1'b1;
         end else begin
            r_wr_ptr           <= (r_wr_ptr == w_last) ? '0 : r_wr_ptr + PW'(1);
            r_valid[r_wr_ptr]  <= w_vin;
            r_vout             <= w_bypass ? w_vin : r_valid[w_rd_ptr];
            r_byp_data         <= bus.din;
         end
      end
   end

   assign bus.dout  = w_bypass ? r_byp_data : w_rd_data;
   assign bus.vout  = (USE_V != 0) ? r_vout : {LANES{r_state == ST_RUN}};
   assign o_busy    = (r_state == ST_FILL);
   assign o_delay_q = r_delay_q;
   assign o_cfg_err = r_cfg_err;
endmodule

// File: tb/tb_pipe_bus_bram_prog.sv
// Randomized bench for pipe_bus_bram_prog against a sample-history reference model.
module tb_pipe_bus_bram_prog;
   localparam int unsigned W     = 256;
   localparam int unsigned LANES = 4;
   localparam int          DMAX  = 64;
   localparam int unsigned DW    = 7;

   typedef logic [LANES*W-1:0] data_t;

   logic          clk = 1'b0;
   logic          rst, ce, cfg_load;
   logic [DW-1:0] cfg_delay;
   logic          busy, cfg_err;
   logic [DW-1:0] delay_q;

   pipe_bus_bram_prog_if #(.W(W), .LANES(LANES)) bus ();

   pipe_bus_bram_prog #(.W(W), .LANES(LANES), .D_MAX(64), .D_DEFAULT(6), .USE_V(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_ce        (ce),
      .i_cfg_load  (cfg_load),
      .i_cfg_delay (cfg_delay),
      .bus         (bus),
      .o_busy      (busy),
      .o_delay_q   (delay_q),
      .o_cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   // Reference model: every accepted sample since the last flush, and the active delay
   data_t            hist_d[$];
   logic [LANES-1:0] hist_v[$];
   int               n_acc, m_len;
   logic             m_err;
   int               n_cmp = 0;
   int               n_bad = 0;

   function automatic data_t mk_cnt(input int v);
      data_t r;
      for (int l = 0; l < int'(LANES); l++) r[l*W +: W] = W'(v + l);
      return r;
   endfunction

   function automatic data_t mk_rand();
      data_t r;
      for (int j = 0; j < int'(LANES*W/32); j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick(input logic r, input logic c, input logic ld, input int cfg,
                       input data_t d, input logic [LANES-1:0] v);
      @(negedge clk);
      rst = r; ce = c; cfg_load = ld; cfg_delay = DW'(cfg); bus.din = d; bus.vin = v;
      @(posedge clk);
      if (r) begin
         hist_d.delete(); hist_v.delete(); n_acc = 0; m_len = 6; m_err = 1'b0;
      end else if (c) begin
         if (ld) begin
            hist_d.delete(); hist_v.delete(); n_acc = 0;
            m_len = (cfg == 0) ? 1 : (cfg > DMAX) ? DMAX : cfg;
            if (cfg == 0 || cfg > DMAX) m_err = 1'b1;
         end else begin
            hist_d.push_back(d); hist_v.push_back(v); n_acc++;
         end
      end
      #1;
   endtask

   // Output expected now: the sample accepted m_len ce-cycles ago, nothing while filling
   task automatic expect_out(output logic [LANES-1:0] ev, output data_t ed, output logic eb);
      eb = (n_acc < m_len);
      if (n_acc >= m_len) begin
         ev = hist_v[n_acc - m_len];
         ed = hist_d[n_acc - m_len];
      end else begin
         ev = '0;
         ed = '0;
      end
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0, 0, '0, '0);
      n_cmp++;
      if (bus.vout !== '0) begin n_bad++; $display("FAIL reset_vout got=%h exp=0", bus.vout); end
      n_cmp++;
      if (bus.dout !== '0) begin n_bad++; $display("FAIL reset_dout got nonzero exp=0"); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
      n_cmp++;
      if (delay_q !== DW'(6)) begin n_bad++; $display("FAIL reset_delay got=%0d exp=6", delay_q); end
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
   endtask

   task automatic test_stream();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      for (int k = 0; k < 30; k++) begin
         tick(1'b0, 1'b1, 1'b0, 0, mk_cnt(100 + k), 4'hF);
         expect_out(ev, ed, eb);
         n_cmp++;
         if (bus.vout !== ev) begin n_bad++; $display("FAIL stream_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
         n_cmp++;
         if (busy !== eb) begin n_bad++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", k, busy, eb); end
         for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
            n_cmp++;
            if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
               n_bad++; $display("FAIL stream_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
            end
         end
      end
   endtask

   task automatic test_delays();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      int dl[3] = '{1, 2, 64};
      foreach (dl[i]) begin
         tick(1'b0, 1'b1, 1'b1, dl[i], mk_rand(), 4'hF);
         n_cmp++;
         if (delay_q !== DW'(dl[i])) begin n_bad++; $display("FAIL delay_load got=%0d exp=%0d", delay_q, dl[i]); end
         for (int k = 0; k < 2 * dl[i] + 12; k++) begin
            tick(1'b0, 1'b1, 1'b0, 0, mk_cnt(1000 * (i + 1) + k), 4'hF);
            expect_out(ev, ed, eb);
            n_cmp++;
            if (bus.vout !== ev) begin n_bad++; $display("FAIL delay%0d_vout cyc=%0d got=%h exp=%h", dl[i], k, bus.vout, ev); end
            n_cmp++;
            if (busy !== eb) begin n_bad++; $display("FAIL delay%0d_busy cyc=%0d got=%b exp=%b", dl[i], k, busy, eb); end
            for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
               n_cmp++;
               if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
                  n_bad++; $display("FAIL delay%0d_dout cyc=%0d lane=%0d got=%h exp=%h", dl[i], k, l, bus.dout[l*W +: W], ed[l*W +: W]);
               end
            end
         end
      end
   endtask

   task automatic test_sparse_valid();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      logic [LANES-1:0] pat[3] = '{4'b0101, 4'b1010, 4'b0000};
      logic [LANES-1:0] v;
      tick(1'b0, 1'b1, 1'b1, 5, mk_rand(), 4'hF);
      for (int k = 0; k < 40; k++) begin
         v = (k < 18) ? pat[k % 3] : LANES'($urandom);
         tick(1'b0, 1'b1, 1'b0, 0, mk_rand(), v);
         expect_out(ev, ed, eb);
         n_cmp++;
         if (bus.vout !== ev) begin n_bad++; $display("FAIL sparse_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
         for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
            n_cmp++;
            if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
               n_bad++; $display("FAIL sparse_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
            end
         end
      end
   endtask

   task automatic test_ce_toggle();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      tick(1'b0, 1'b1, 1'b1, 8, mk_rand(), 4'hF);
      for (int k = 0; k < 90; k++) begin
         tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, mk_rand(), LANES'($urandom));
         expect_out(ev, ed, eb);
         n_cmp++;
         if (bus.vout !== ev) begin n_bad++; $display("FAIL ce_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
         n_cmp++;
         if (busy !== eb) begin n_bad++; $display("FAIL ce_busy cyc=%0d got=%b exp=%b", k, busy, eb); end
         for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
            n_cmp++;
            if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
               n_bad++; $display("FAIL ce_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
            end
         end
      end
   endtask

   task automatic test_cfg_err();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      int req[2] = '{0, 100};
      foreach (req[i]) begin
         for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0, 0, mk_rand(), 4'hF);
         tick(1'b0, 1'b1, 1'b1, req[i], mk_rand(), 4'hF);
         n_cmp++;
         if (delay_q !== DW'(m_len)) begin n_bad++; $display("FAIL sat_delay req=%0d got=%0d exp=%0d", req[i], delay_q, m_len); end
         for (int k = 0; k < 72; k++) begin
            tick(1'b0, 1'b1, 1'b0, 0, mk_rand(), LANES'($urandom));
            expect_out(ev, ed, eb);
            n_cmp++;
            if (cfg_err !== m_err) begin n_bad++; $display("FAIL err_sticky cyc=%0d got=%b exp=%b", k, cfg_err, m_err); end
            n_cmp++;
            if (bus.vout !== ev) begin n_bad++; $display("FAIL err_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
            for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
               n_cmp++;
               if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
                  n_bad++; $display("FAIL err_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      tick(1'b0, 1'b1, 1'b1, 10, mk_rand(), 4'hF);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b0, 0, mk_rand(), 4'hF);
      tick(1'b0, 1'b1, 1'b1, 4, mk_rand(), 4'hF);
      for (int k = 0; k < 12; k++) begin
         tick(1'b0, 1'b1, 1'b0, 0, mk_cnt(5000 + k), 4'hF);
         expect_out(ev, ed, eb);
         n_cmp++;
         if (busy !== eb) begin n_bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", k, busy, eb); end
         n_cmp++;
         if (bus.vout !== ev) begin n_bad++; $display("FAIL b2b_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
         for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
            n_cmp++;
            if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
               n_bad++; $display("FAIL b2b_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
            end
         end
      end
   endtask

   task automatic test_rst_with_load();
      logic [LANES-1:0] ev; data_t ed; logic eb;
      for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b0, 0, mk_rand(), 4'hF);
      tick(1'b1, 1'b1, 1'b1, 3, mk_rand(), 4'hF);
      n_cmp++;
      if (bus.vout !== '0) begin n_bad++; $display("FAIL rstld_vout got=%h exp=0", bus.vout); end
      n_cmp++;
      if (bus.dout !== '0) begin n_bad++; $display("FAIL rstld_dout got nonzero exp=0"); end
      n_cmp++;
      if (delay_q !== DW'(6)) begin n_bad++; $display("FAIL rstld_delay got=%0d exp=6", delay_q); end
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rstld_err got=%b exp=0", cfg_err); end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL rstld_busy got=%b exp=1", busy); end
      for (int k = 0; k < 12; k++) begin
         tick(1'b0, 1'b1, 1'b0, 0, mk_cnt(7000 + k), 4'hF);
         expect_out(ev, ed, eb);
         n_cmp++;
         if (busy !== eb) begin n_bad++; $display("FAIL rstld_fill_busy cyc=%0d got=%b exp=%b", k, busy, eb); end
         n_cmp++;
         if (bus.vout !== ev) begin n_bad++; $display("FAIL rstld_fill_vout cyc=%0d got=%h exp=%h", k, bus.vout, ev); end
         for (int l = 0; l < int'(LANES); l++) if (ev[l]) begin
            n_cmp++;
            if (bus.dout[l*W +: W] !== ed[l*W +: W]) begin
               n_bad++; $display("FAIL rstld_fill_dout cyc=%0d lane=%0d got=%h exp=%h", k, l, bus.dout[l*W +: W], ed[l*W +: W]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; cfg_load = 1'b0; cfg_delay = '0; bus.din = '0; bus.vin = '0;
      n_acc = 0; m_len = 6; m_err = 1'b0;
      test_reset();
      test_stream();
      test_delays();
      test_sparse_valid();
      test_ce_toggle();
      test_cfg_err();
      test_back_to_back();
      test_rst_with_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
